// File: rtl/glyph_scan_pipe_pkg.sv
// Shared constants and types for the glyph scan pipeline.
package glyph_scan_pipe_pkg;

   localparam int PIPE_LATENCY = 4;
   localparam int GLYPH_COLS   = 3;
   localparam int GLYPH_ROWS   = 5;

   localparam logic [1:0] SPACER_COL       = 2'(GLYPH_COLS);
   localparam logic [2:0] FIRST_SPACER_ROW = 3'(GLYPH_ROWS);

   typedef logic [5:0] rgb222_t;

endpackage

// File: rtl/glyph_delay_line.sv
// Fixed-depth shift register used to keep side-band flags aligned with pixel data.
module glyph_delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clock,
   input  logic             rst,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] delayed
);

   logic [WIDTH-1:0] taps [DEPTH];

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
      end else begin
         taps[0] <= data;
         for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
      end
   end

   assign delayed = taps[DEPTH-1];

endmodule

// File: rtl/glyph_scan_pipe.sv
// Maps the VGA active-pixel stream onto glyph store coordinates and renders the returned bit.
// Build option: define GLYPH_BLINK_EN for a 64-frame cursor blink on character cell (0,0).
module glyph_scan_pipe
   import glyph_scan_pipe_pkg::*;
#(
   parameter int      SCALE_X  = 4,
   parameter int      SCALE_Y  = 4,
   parameter int      CELLS_X  = 40,
   parameter int      CELLS_Y  = 15,
   parameter rgb222_t FG_COLOR = 6'b111111,
   parameter rgb222_t BG_COLOR = 6'b000000
) (
   input  logic                       clock,
   input  logic                       rst,
   input  logic                       pix_valid,
   input  logic                       line_start,
   input  logic                       frame_start,
   input  logic                       hsync_in,
   input  logic                       vsync_in,
   output logic [2:0]                 glyph_y,
   output logic [1:0]                 glyph_x,
   input  logic                       glyph_bit,
   output logic [$clog2(CELLS_X)-1:0] cell_col,
   output logic [$clog2(CELLS_Y)-1:0] cell_row,
   output rgb222_t                    rgb_out,
   output logic                       hsync_out,
   output logic                       vsync_out,
   output logic                       active_out
);

   localparam int SXW = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
   localparam int SYW = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;
   localparam int CCW = $clog2(CELLS_X);
   localparam int CRW = $clog2(CELLS_Y);

   localparam logic [SXW-1:0] SX_LAST = SXW'(SCALE_X - 1);
   localparam logic [SYW-1:0] SY_LAST = SYW'(SCALE_Y - 1);
   localparam logic [CCW-1:0] CC_LAST = CCW'(CELLS_X - 1);
   localparam logic [CRW-1:0] CR_LAST = CRW'(CELLS_Y - 1);

   logic [SXW-1:0] sub_x, cur_sub_x, nxt_sub_x;
   logic [1:0]     col, cur_col, nxt_col;
   logic [CCW-1:0] ccol, cur_ccol, nxt_ccol;
   logic [SYW-1:0] sub_y, cur_sub_y, nxt_sub_y;
   logic [2:0]     row, cur_row, nxt_row;
   logic [CRW-1:0] crow, cur_crow, nxt_crow;
   logic           pv_d, line_end, cursor_off, blank_p0;
   logic [1:0]     col_p1;
   logic           hs_p3, vs_p3, vld_p3, blank_p3;

   // Coordinates of the pixel presented this cycle: start pulses zero them immediately.
   always_comb begin
      cur_sub_x = line_start  ? '0 : sub_x;
      cur_col   = line_start  ? '0 : col;
      cur_ccol  = line_start  ? '0 : ccol;
      cur_sub_y = frame_start ? '0 : sub_y;
      cur_row   = frame_start ? '0 : row;
      cur_crow  = frame_start ? '0 : crow;
      line_end  = pv_d & ~pix_valid;

      nxt_sub_x = cur_sub_x;
      nxt_col   = cur_col;
      nxt_ccol  = cur_ccol;
      if (pix_valid) begin
         if (cur_sub_x == SX_LAST) begin
            nxt_sub_x = '0;
            nxt_col   = cur_col + 2'd1;
            if (cur_col == 2'd3 && cur_ccol != CC_LAST) nxt_ccol = cur_ccol + CCW'(1);
         end else begin
            nxt_sub_x = cur_sub_x + SXW'(1);
         end
      end

      nxt_sub_y = cur_sub_y;
      nxt_row   = cur_row;
      nxt_crow  = cur_crow;
      if (!frame_start && line_end) begin
         if (sub_y == SY_LAST) begin
            nxt_sub_y = '0;
            nxt_row   = row + 3'd1;
            if (row == 3'd7 && crow != CR_LAST) nxt_crow = crow + CRW'(1);
         end else begin
            nxt_sub_y = sub_y + SYW'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         sub_x <= '0;
         col   <= '0;
         ccol  <= '0;
         sub_y <= '0;
         row   <= '0;
         crow  <= '0;
         pv_d  <= 1'b0;
      end else begin
         sub_x <= nxt_sub_x;
         col   <= nxt_col;
         ccol  <= nxt_ccol;
         sub_y <= nxt_sub_y;
         row   <= nxt_row;
         crow  <= nxt_crow;
         pv_d  <= pix_valid;
      end
   end

`ifdef GLYPH_BLINK_EN
   logic [5:0] frame_cnt;
   logic [5:0] frame_idx;

   always_ff @(posedge clock or posedge rst) begin
      if (rst)              frame_cnt <= '0;
      else if (frame_start) frame_cnt <= frame_cnt + 6'd1;
   end

   // The counter already holds the number of frames begun; the current frame is one behind.
   assign frame_idx  = frame_start ? frame_cnt : frame_cnt - 6'd1;
   assign cursor_off = frame_idx[5] && (cur_ccol == '0) && (cur_crow == '0);
`else
   assign cursor_off = 1'b0;
`endif

   assign blank_p0 = (cur_col == SPACER_COL) || (cur_row >= FIRST_SPACER_ROW) || cursor_off;

   // Stage 1: row select and cell indices to the store
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         glyph_y  <= '0;
         cell_col <= '0;
         cell_row <= '0;
         col_p1   <= '0;
      end else begin
         glyph_y  <= cur_row;
         cell_col <= cur_ccol;
         cell_row <= cur_crow;
         col_p1   <= cur_col;
      end
   end

   // Stage 2: column select, one cycle behind the row
   always_ff @(posedge clock or posedge rst) begin
      if (rst) glyph_x <= '0;
      else     glyph_x <= col_p1;
   end

   glyph_delay_line #(
      .WIDTH (4),
      .DEPTH (PIPE_LATENCY - 1)
   ) u_align (
      .clock   (clock),
      .rst     (rst),
      .data    ({hsync_in, vsync_in, pix_valid, blank_p0}),
      .delayed ({hs_p3, vs_p3, vld_p3, blank_p3})
   );

   // Stage 4: colour select against the returned glyph bit
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         rgb_out    <= BG_COLOR;
         hsync_out  <= 1'b0;
         vsync_out  <= 1'b0;
         active_out <= 1'b0;
      end else begin
         rgb_out    <= (vld_p3 && !blank_p3 && glyph_bit) ? FG_COLOR : BG_COLOR;
         hsync_out  <= hs_p3;
         vsync_out  <= vs_p3;
         active_out <= vld_p3;
      end
   end

endmodule
